// File: rtl/bus_dma_master.sv
// Bus-initiator DMA engine: copies LEN bytes from a source window to a destination
// window on the shared 8-bit peripheral bus, four bus cycles per byte.
module bus_dma_master #(
   parameter logic [7:0] IDLE_ADDR = 8'hFF
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       START,
   input  logic [7:0] SRC_BASE,
   input  logic [7:0] DST_BASE,
   input  logic [7:0] LEN,
   input  logic       BUS_GNT,
   output logic       BUS_REQ,
   output logic [7:0] BUS_ADDR,
   output logic       BUS_WE,
   inout  wire  [7:0] BUS_DATA,
   output logic       BUSY,
   output logic       DONE,
   output logic [7:0] LAST_DATA
);

   localparam int unsigned AW = 8;
   localparam int unsigned SW = 3;

   localparam logic [SW-1:0] S_IDLE     = 3'd0;
   localparam logic [SW-1:0] S_WAIT_GNT = 3'd1;
   localparam logic [SW-1:0] S_RD_ADDR  = 3'd2;
   localparam logic [SW-1:0] S_RD_DATA  = 3'd3;
   localparam logic [SW-1:0] S_TURN     = 3'd4;
   localparam logic [SW-1:0] S_WR       = 3'd5;
   localparam logic [SW-1:0] S_DONE     = 3'd6;

   logic [SW-1:0] state, nxt_state;
   logic [AW-1:0] src, nxt_src;
   logic [AW-1:0] dst, nxt_dst;
   logic [AW-1:0] len, nxt_len;
   logic [AW-1:0] idx, nxt_idx;
   logic [AW-1:0] data_q;
   logic [AW-1:0] nxt_addr;
   logic          nxt_we;
   logic          nxt_busy;
   logic          nxt_done;
   logic          last_byte;

   // Next-state and transfer bookkeeping.
   // With grant still held at the end of a write the next byte starts at once,
   // giving back-to-back 4-cycle bytes; without it the block re-waits for grant.
   always_comb begin
      nxt_state = state;
      nxt_src   = src;
      nxt_dst   = dst;
      nxt_len   = len;
      nxt_idx   = idx;
      last_byte = ((idx + AW'(1)) == len);
      case (state)
         S_IDLE: begin
            if (START) begin
               if (LEN != '0) begin
                  nxt_state = S_WAIT_GNT;
                  nxt_src   = SRC_BASE;
                  nxt_dst   = DST_BASE;
                  nxt_len   = LEN;
                  nxt_idx   = '0;
               end else begin
                  nxt_state = S_DONE;
               end
            end
         end
         S_WAIT_GNT: begin
            if (BUS_GNT) nxt_state = S_RD_ADDR;
         end
         S_RD_ADDR: nxt_state = S_RD_DATA;
         S_RD_DATA: nxt_state = S_TURN;
         S_TURN:    nxt_state = S_WR;
         S_WR: begin
            nxt_idx = idx + AW'(1);
            if (last_byte)    nxt_state = S_DONE;
            else if (BUS_GNT) nxt_state = S_RD_ADDR;
            else              nxt_state = S_WAIT_GNT;
         end
         S_DONE:  nxt_state = S_IDLE;
         default: nxt_state = S_IDLE;
      endcase
   end

   // Output decode from the state being entered, so every output is a flop.
   always_comb begin
      nxt_addr = IDLE_ADDR;
      nxt_we   = 1'b0;
      nxt_busy = 1'b0;
      nxt_done = 1'b0;
      case (nxt_state)
         S_WAIT_GNT, S_TURN: nxt_busy = 1'b1;
         S_RD_ADDR, S_RD_DATA: begin
            nxt_addr = nxt_src + nxt_idx;
            nxt_busy = 1'b1;
         end
         S_WR: begin
            nxt_addr = nxt_dst + nxt_idx;
            nxt_we   = 1'b1;
            nxt_busy = 1'b1;
         end
         S_DONE:  nxt_done = 1'b1;
         default: nxt_busy = 1'b0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= S_IDLE;
         src       <= '0;
         dst       <= '0;
         len       <= '0;
         idx       <= '0;
         data_q    <= '0;
         BUS_ADDR  <= IDLE_ADDR;
         BUS_WE    <= 1'b0;
         BUS_REQ   <= 1'b0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         LAST_DATA <= '0;
      end else begin
         state    <= nxt_state;
         src      <= nxt_src;
         dst      <= nxt_dst;
         len      <= nxt_len;
         idx      <= nxt_idx;
         BUS_ADDR <= nxt_addr;
         BUS_WE   <= nxt_we;
         BUS_REQ  <= nxt_busy;
         BUSY     <= nxt_busy;
         DONE     <= nxt_done;
         // Responder drives read data during RD_DATA; take it at that state's exit edge.
         if (state == S_RD_DATA) begin
            data_q    <= BUS_DATA;
            LAST_DATA <= BUS_DATA;
         end
      end
   end

   // Drive enable is the registered write strobe and nothing else.
   assign BUS_DATA = BUS_WE ? data_q : {AW{1'bz}};

endmodule

// File: tb/tb_bus_dma_master.sv
// Directed bench for bus_dma_master with a registered-read memory responder on the bus.
module tb_bus_dma_master;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] src_base, dst_base, len;
   logic       bus_gnt;
   logic       bus_req;
   logic [7:0] bus_addr;
   logic       bus_we;
   wire  [7:0] bus_data;
   logic       busy;
   logic       done;
   logic [7:0] last_data;

   always #5 clk = ~clk;

   bus_dma_master #(.IDLE_ADDR(8'hFF)) dut (
      .CLK(clk), .RESET(reset), .START(start),
      .SRC_BASE(src_base), .DST_BASE(dst_base), .LEN(len),
      .BUS_GNT(bus_gnt), .BUS_REQ(bus_req), .BUS_ADDR(bus_addr),
      .BUS_WE(bus_we), .BUS_DATA(bus_data), .BUSY(busy),
      .DONE(done), .LAST_DATA(last_data)
   );

   // Memory responder: samples address, drives registered read data the next cycle.
   // qual_mode maps address FF too, and then only drives while the read address is held.
   logic [7:0] mem [256];
   logic [7:0] rd_addr_q, rdata_q;
   logic       en_q = 1'b0;
   logic       qual_mode;
   logic       resp_drive;

   always @(posedge clk) begin
      if (bus_we && (qual_mode || bus_addr != 8'hFF)) mem[bus_addr] = bus_data;
      en_q      <= !bus_we && (qual_mode || bus_addr != 8'hFF);
      rd_addr_q <= bus_addr;
      rdata_q   <= mem[bus_addr];
   end

   assign resp_drive = qual_mode ? (en_q && bus_addr == rd_addr_q && !bus_we) : en_q;
   assign bus_data   = resp_drive ? rdata_q : 8'hzz;

   int contention_cnt = 0;
   int req_bad_cnt    = 0;
   always @(negedge clk) begin
      if (resp_drive && bus_we) contention_cnt++;
      if (bus_req !== busy) req_bad_cnt++;
   end

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // START is presented for one cycle (cycle 0); returns sitting in cycle 1.
   task automatic start_xfer(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
      src_base = s;
      dst_base = d;
      len      = l;
      start    = 1'b1;
      step();
      start = 1'b0;
   endtask

   logic [7:0] tr_a [$];
   logic       tr_we [$];
   int         busy_cnt;
   int         done_cyc;

   // Record the bus from cycle 'base' until DONE is seen or the budget runs out.
   task automatic watch(input int base, input int max_cyc);
      tr_a.delete();
      tr_we.delete();
      busy_cnt = 0;
      done_cyc = 0;
      for (int c = base; c < base + max_cyc; c++) begin
         tr_a.push_back(bus_addr);
         tr_we.push_back(bus_we);
         if (busy) busy_cnt++;
         if (done) begin
            done_cyc = c;
            break;
         end
         step();
      end
   endtask

   int stall_bad;
   int dones;

   initial begin
      reset = 1'b1; start = 1'b0; bus_gnt = 1'b1; qual_mode = 1'b0;
      src_base = '0; dst_base = '0; len = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      step(); step();
      check("rst_addr", bus_addr, 8'hFF);
      check("rst_we", bus_we, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_req", bus_req, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_last", last_data, 8'h00);
      reset = 1'b0;
      step();

      // Single byte, grant held.
      mem[8'h10] = 8'hA5;
      start_xfer(8'h10, 8'h20, 8'd1);
      watch(1, 12);
      check("t1_done_cyc", done_cyc, 6);
      check("t1_busy_cnt", busy_cnt, 5);
      check("t1_busy_at_done", busy, 1'b0);
      check("t1_a1", tr_a[0], 8'hFF);
      check("t1_a2", tr_a[1], 8'h10);
      check("t1_a3", tr_a[2], 8'h10);
      check("t1_a4", tr_a[3], 8'hFF);
      check("t1_a5", tr_a[4], 8'h20);
      check("t1_we_seq", {tr_we[1], tr_we[2], tr_we[3], tr_we[4]}, 4'b0001);
      check("t1_mem20", mem[8'h20], 8'hA5);
      check("t1_last", last_data, 8'hA5);
      step();
      check("t1_done_pulse", done, 1'b0);
      check("t1_idle_addr", bus_addr, 8'hFF);

      // Four bytes back to back.
      mem[8'h30] = 8'h11; mem[8'h31] = 8'h22; mem[8'h32] = 8'h33; mem[8'h33] = 8'h44;
      start_xfer(8'h30, 8'h40, 8'd4);
      watch(1, 30);
      check("t2_done_cyc", done_cyc, 18);
      check("t2_busy_cnt", busy_cnt, 17);
      check("t2_a_b3_rd", tr_a[13], 8'h33);
      check("t2_a_b3_wr", tr_a[16], 8'h43);
      check("t2_mem40", mem[8'h40], 8'h11);
      check("t2_mem41", mem[8'h41], 8'h22);
      check("t2_mem42", mem[8'h42], 8'h33);
      check("t2_mem43", mem[8'h43], 8'h44);
      check("t2_last", last_data, 8'h44);
      step();

      // Address wrap with overlapping windows.
      qual_mode = 1'b1;
      mem[8'hFE] = 8'h5A; mem[8'hFF] = 8'hC3; mem[8'h00] = 8'h00;
      start_xfer(8'hFE, 8'hFF, 8'd2);
      watch(1, 20);
      check("t3_done_cyc", done_cyc, 10);
      check("t3_rd0", tr_a[1], 8'hFE);
      check("t3_wr0", {tr_a[4], 7'd0, tr_we[4]}, {8'hFF, 8'h01});
      check("t3_rd1", tr_a[5], 8'hFF);
      check("t3_wr1", {tr_a[8], 7'd0, tr_we[8]}, {8'h00, 8'h01});
      check("t3_memFF", mem[8'hFF], 8'h5A);
      check("t3_mem00", mem[8'h00], 8'h5A);
      check("t3_last", last_data, 8'h5A);
      step();
      qual_mode = 1'b0;

      // LEN = 0.
      start_xfer(8'h12, 8'h34, 8'd0);
      watch(1, 6);
      check("t4_done_cyc", done_cyc, 1);
      check("t4_busy_cnt", busy_cnt, 0);
      check("t4_addr", tr_a[0], 8'hFF);
      step();
      check("t4_done_pulse", done, 1'b0);
      check("t4_busy_after", busy, 1'b0);

      // Grant stalls, grant dropped during RD_DATA.
      mem[8'h50] = 8'h9C; mem[8'h51] = 8'hE7;
      bus_gnt = 1'b0;
      stall_bad = 0;
      start_xfer(8'h50, 8'h60, 8'd2);
      for (int c = 1; c <= 5; c++) begin
         if (bus_addr !== 8'hFF || bus_we !== 1'b0 || busy !== 1'b1) stall_bad++;
         if (c == 5) bus_gnt = 1'b1;
         else step();
      end
      step();
      check("t5_b0_start", bus_addr, 8'h50);
      step();
      bus_gnt = 1'b0;
      step(); step();
      check("t5_b0_wr", {bus_addr, 7'd0, bus_we}, {8'h60, 8'h01});
      for (int c = 10; c <= 14; c++) begin
         step();
         if (bus_addr !== 8'hFF || bus_we !== 1'b0) stall_bad++;
      end
      bus_gnt = 1'b1;
      step();
      check("t5_b1_start", bus_addr, 8'h51);
      watch(15, 12);
      check("t5_stall_bad", stall_bad, 0);
      check("t5_done_cyc", done_cyc, 19);
      check("t5_mem60", mem[8'h60], 8'h9C);
      check("t5_mem61", mem[8'h61], 8'hE7);
      check("t5_last", last_data, 8'hE7);
      step();

      // START while busy is ignored.
      mem[8'h70] = 8'h01; mem[8'h71] = 8'h02; mem[8'h90] = 8'hFE; mem[8'h91] = 8'hFD;
      mem[8'h80] = 8'h00; mem[8'h81] = 8'h00; mem[8'hA0] = 8'h00;
      start_xfer(8'h70, 8'h80, 8'd2);
      step(); step();
      start_xfer(8'h90, 8'hA0, 8'd5);
      watch(4, 20);
      check("t6_done_cyc", done_cyc, 10);
      check("t6_mem80", mem[8'h80], 8'h01);
      check("t6_mem81", mem[8'h81], 8'h02);
      check("t6_memA0", mem[8'hA0], 8'h00);
      check("t6_last", last_data, 8'h02);
      step();

      // Reset during the write of the second of four bytes.
      mem[8'hB0] = 8'h05; mem[8'hB1] = 8'h06; mem[8'hB2] = 8'h07; mem[8'hB3] = 8'h08;
      start_xfer(8'hB0, 8'hC0, 8'd4);
      for (int c = 1; c < 9; c++) step();
      check("t7_in_wr", {bus_addr, 7'd0, bus_we}, {8'hC1, 8'h01});
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t7_we", bus_we, 1'b0);
      check("t7_busy", busy, 1'b0);
      check("t7_addr", bus_addr, 8'hFF);
      check("t7_last", last_data, 8'h00);
      check("t7_memC0", mem[8'hC0], 8'h05);
      dones = 0;
      for (int c = 0; c < 20; c++) begin
         if (done) dones++;
         step();
      end
      check("t7_no_done", dones, 0);
      start_xfer(8'hB0, 8'hD0, 8'd1);
      watch(1, 12);
      check("t7_restart_done", done_cyc, 6);
      check("t7_memD0", mem[8'hD0], 8'h05);
      step();

      check("contention", contention_cnt, 0);
      check("req_eq_busy", req_bad_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
